// File: rtl/gcd_pkg.sv
// Shared types and default sizing for the subtractive GCD engine.
package gcd_pkg;

    localparam int GCD_W_DEF     = 16;
    localparam int GCD_CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } gcd_state_t;

endpackage : gcd_pkg

// File: rtl/gcd_engine_if.sv
// Operand/result handshake bundle between a producer/consumer and gcd_engine.
interface gcd_engine_if #(
    parameter int W     = gcd_pkg::GCD_W_DEF,
    parameter int CNT_W = gcd_pkg::GCD_CNT_W_DEF
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic             abort;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     result;
    logic [CNT_W-1:0] cycles;

    modport master (
        output in_valid,
        output in_a,
        output in_b,
        output abort,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  result,
        input  cycles
    );

    modport slave (
        input  in_valid,
        input  in_a,
        input  in_b,
        input  abort,
        input  out_ready,
        output in_ready,
        output out_valid,
        output result,
        output cycles
    );

endinterface : gcd_engine_if

// File: rtl/gcd_datapath.sv
// A/B operand registers, compare/subtract/swap step logic, result register and
// saturating step counter, all sequenced by the gcd_engine control FSM.
module gcd_datapath
    import gcd_pkg::*;
#(
    parameter int W     = GCD_W_DEF,
    parameter int CNT_W = GCD_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             cnt_en,
    input  logic             swap,
    input  logic             sub,
    input  logic             done,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    output logic             a_zero,
    output logic             b_lt_a,
    output logic [W-1:0]     result,
    output logic [CNT_W-1:0] cycles
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;

    assign a_zero = (a == '0);
    assign b_lt_a = (b < a);
    // Only selected when b >= a, so the unsigned difference never wraps.
    assign diff   = b - a;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a      <= '0;
            b      <= '0;
            result <= '0;
            cycles <= '0;
        end else if (load) begin
            a      <= in_a;
            b      <= in_b;
            cycles <= '0;
        end else begin
            if (swap) begin
                a <= b;
                b <= a;
            end else if (sub) begin
                b <= diff;
            end
            if (done) begin
                result <= b;
            end
            if (cnt_en && (cycles != CNT_MAX)) begin
                cycles <= cycles + CNT_W'(1);
            end
        end
    end

endmodule : gcd_datapath

// File: rtl/gcd_engine.sv
// Subtractive GCD engine: control FSM plus gcd_datapath, with a valid/ready
// operand port, valid/ready result port and an abort for runs in progress.
module gcd_engine
    import gcd_pkg::*;
#(
    parameter int W     = GCD_W_DEF,
    parameter int CNT_W = GCD_CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    gcd_engine_if.slave  bus
);

    // state | meaning
    // IDLE  | waiting for an operand pair; in_ready high
    // CALC  | one compare/swap/subtract step per cycle until A reaches 0
    // DONE  | result and cycles held; out_valid high until out_ready

    gcd_state_t state;
    gcd_state_t state_nx;

    logic load;
    logic cnt_en;
    logic swap;
    logic sub;
    logic done;
    logic a_zero;
    logic b_lt_a;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    state_nx = CALC;
                end
            end
            CALC: begin
                if (bus.abort) begin
                    state_nx = IDLE;
                end else if (a_zero) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Abort wins over the step so a cancelled run never writes a result.
    always_comb begin
        load   = 1'b0;
        cnt_en = 1'b0;
        swap   = 1'b0;
        sub    = 1'b0;
        done   = 1'b0;
        case (state)
            IDLE: begin
                load = bus.in_valid;
            end
            CALC: begin
                if (!bus.abort) begin
                    cnt_en = 1'b1;
                    if (a_zero) begin
                        done = 1'b1;
                    end else if (b_lt_a) begin
                        swap = 1'b1;
                    end else begin
                        sub = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);

    gcd_datapath #(
        .W     (W),
        .CNT_W (CNT_W)
    ) u_datapath (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .cnt_en (cnt_en),
        .swap   (swap),
        .sub    (sub),
        .done   (done),
        .in_a   (bus.in_a),
        .in_b   (bus.in_b),
        .a_zero (a_zero),
        .b_lt_a (b_lt_a),
        .result (bus.result),
        .cycles (bus.cycles)
    );

endmodule : gcd_engine

// File: tb/tb_gcd_engine.sv
// Directed and random checks of gcd_engine against a scoreboard of expected
// result, step count and acceptance-to-valid latency.
module tb_gcd_engine;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    gcd_engine_if #(.W(16), .CNT_W(8)) bus ();

    gcd_engine #(.W(16), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int unsigned res;
        int unsigned cyc;
        int unsigned lat;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int unsigned ref_gcd(input int unsigned a_in, input int unsigned b_in);
        int unsigned a, b, t;
        a = a_in;
        b = b_in;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic int unsigned ref_steps(input int unsigned a_in, input int unsigned b_in);
        int unsigned a, b, t, n;
        a = a_in;
        b = b_in;
        n = 0;
        forever begin
            n++;
            if (a == 0) break;
            if (b < a) begin
                t = a;
                a = b;
                b = t;
            end else begin
                b = b - a;
            end
        end
        return n;
    endfunction

    task automatic run(input logic [15:0] a, input logic [15:0] b,
                       input int unsigned er, input int unsigned ec,
                       input int unsigned el, input int hold);
        exp_t e;
        exp_t got;
        int   lat;
        e.res = er;
        e.cyc = ec;
        e.lat = el;
        exp_q.push_back(e);
        @(negedge clk);
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_valid = 1'b1;
        lat = 0;
        while (!bus.in_ready && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("accept_ready", 32'(bus.in_ready), 1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 70000) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        got = exp_q.pop_front();
        check("out_valid", 32'(bus.out_valid), 1);
        check("latency", 32'(lat), got.lat);
        check("result", 32'(bus.result), got.res);
        check("cycles", 32'(bus.cycles), got.cyc);
        for (int i = 0; i < hold; i++) begin
            bus.abort = 1'b1;
            @(negedge clk);
            check("hold_result", 32'(bus.result), got.res);
            check("hold_cycles", 32'(bus.cycles), got.cyc);
            check("hold_in_ready", 32'(bus.in_ready), 0);
            check("hold_out_valid", 32'(bus.out_valid), 1);
        end
        bus.abort     = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("post_hs_in_ready", 32'(bus.in_ready), 1);
        check("post_hs_out_valid", 32'(bus.out_valid), 0);
    endtask

    initial begin
        int unsigned ra, rb, st;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.abort     = 1'b0;
        bus.out_ready = 1'b0;
        #12;
        check("rst_result", 32'(bus.result), 0);
        check("rst_cycles", 32'(bus.cycles), 0);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 1);

        run(16'd12, 16'd8, 4, 7, 8, 5);
        run(16'd0, 16'd0, 0, 1, 2, 0);
        run(16'd5, 16'd0, 5, 2, 3, 0);
        run(16'd0, 16'd9, 9, 1, 2, 0);

        // Abort during the third CALC cycle of (100,75).
        @(negedge clk);
        bus.in_a     = 16'd100;
        bus.in_b     = 16'd75;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("abort_busy", 32'(bus.in_ready), 0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        bus.abort = 1'b1;
        check("abort_no_valid_pre", 32'(bus.out_valid), 0);
        @(posedge clk);
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_idle", 32'(bus.in_ready), 1);
        check("abort_no_valid", 32'(bus.out_valid), 0);
        run(16'd100, 16'd75, 25, 8, 9, 0);

        // Asynchronous reset in the middle of a computation.
        @(negedge clk);
        bus.in_a     = 16'd200;
        bus.in_b     = 16'd3;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_result", 32'(bus.result), 0);
        check("mid_rst_cycles", 32'(bus.cycles), 0);
        check("mid_rst_out_valid", 32'(bus.out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(bus.in_ready), 1);
        check("post_rst_out_valid", 32'(bus.out_valid), 0);

        run(16'd1, 16'd65535, 1, 255, 65538, 0);

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom_range(0, 63);
            rb = $urandom_range(0, 63);
            st = ref_steps(ra, rb);
            run(ra[15:0], rb[15:0], ref_gcd(ra, rb), (st > 255) ? 255 : st, st + 1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_gcd_engine
